iir_deemph: RTL and testbench

//  First-order fixed-point IIR de-emphasis filter. Consumes the summed audio stream

---
 rtl/fm_radio_pkg.sv | 36 +++
 rtl/iir_deemph_if.sv | 39 +++
 rtl/iir_deemph.sv | 142 ++++++++++++++
 tb/tb_iir_deemph.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_radio_pkg.sv
// Package: fm_radio_pkg
// Purpose: constants, FSM state type and the dequantize helper shared by the
//          FM radio datapath blocks. The IIR de-emphasis filter uses all of them.
// Contents:
//   DATA_WIDTH    sample width, signed two's complement
//   QUANT_BITS    fixed-point fraction bits
//   iir_state_t   de-emphasis filter FSM states
//   dequantize()  divide a full-width product by 2**QUANT_BITS, truncating
//                 toward zero, and narrow the result to DATA_WIDTH
package fm_radio_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int QUANT_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL0  = 3'd1,
    S_MUL1  = 3'd2,
    S_MUL2  = 3'd3,
    S_WRITE = 3'd4
  } iir_state_t;

  // Added to negative products before the arithmetic shift so the shift
  // rounds toward zero instead of toward minus infinity.
  localparam logic signed [2*DATA_WIDTH-1:0] DQ_BIAS =
    (64'sd1 <<< QUANT_BITS) - 64'sd1;

  function automatic logic signed [DATA_WIDTH-1:0] dequantize(
    input logic signed [2*DATA_WIDTH-1:0] p
  );
    logic signed [2*DATA_WIDTH-1:0] biased;
    biased = p + (p[2*DATA_WIDTH-1] ? DQ_BIAS : '0);
    return DATA_WIDTH'(biased >>> QUANT_BITS);
  endfunction

endpackage

// File: rtl/iir_deemph_if.sv
// Interface: iir_deemph_if
// Purpose: FIFO-side signals of the de-emphasis filter. The input side is a
//          first-word-fall-through FIFO; the output side is a plain push port.
// Handshake: in_dout is valid whenever in_empty is low, and a word is consumed
//   on every rising edge where in_rd_en is high. A word is accepted on every
//   rising edge where out_wr_en is high; out_wr_en is only raised while
//   out_full is low. in_rd_en and out_wr_en are never high in the same cycle.
// Modports:
//   master  filter side (drives in_rd_en, out_wr_en, out_din)
//   slave   FIFO side   (drives in_empty, in_dout, out_full)
interface iir_deemph_if;
  import fm_radio_pkg::*;

  logic                  in_rd_en;
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  out_wr_en;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] out_din;

  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );

endinterface

// File: rtl/iir_deemph.sv
// Module: iir_deemph
// Purpose: first-order fixed-point IIR de-emphasis filter,
//   y[n] = DQ(B0*x[n]) + DQ(B1*x[n-1]) + DQ(A1*y[n-1]),
//   computed with one shared multiplier over three cycles per sample.
// Ports:
//   clock        single clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          iir_deemph_if.master: input FIFO pop, output FIFO push
//   o_dbg_state  current FSM state, for observation only
// Sums wrap modulo 2**DATA_WIDTH. History (x1, y1) only moves on the cycle the
// output word is pushed, so a stall or reset never leaves it half-updated.
module iir_deemph
  import fm_radio_pkg::*;
#(
  parameter logic signed [DATA_WIDTH-1:0] B0 = 178,
  parameter logic signed [DATA_WIDTH-1:0] B1 = 178,
  parameter logic signed [DATA_WIDTH-1:0] A1 = 666
) (
  input  logic         clock,
  input  logic         reset_n,
  iir_deemph_if.master bus,
  output iir_state_t   o_dbg_state
);

  iir_state_t r_state;
  iir_state_t w_next_state;

  logic signed [DATA_WIDTH-1:0]   r_x_cur;
  logic signed [DATA_WIDTH-1:0]   r_x1;
  logic signed [DATA_WIDTH-1:0]   r_y1;
  logic signed [DATA_WIDTH-1:0]   r_acc;
  logic signed [DATA_WIDTH-1:0]   r_out_din;

  logic                           w_rd;
  logic                           w_wr;
  logic signed [DATA_WIDTH-1:0]   w_mul_a;
  logic signed [DATA_WIDTH-1:0]   w_mul_b;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [DATA_WIDTH-1:0]   w_dq;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and handshake strobes
  always_comb begin
    w_next_state = r_state;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.in_empty) begin
          w_rd         = 1'b1;
          w_next_state = S_MUL0;
        end
      end
      S_MUL0:  w_next_state = S_MUL1;
      S_MUL1:  w_next_state = S_MUL2;
      S_MUL2:  w_next_state = S_WRITE;
      S_WRITE: begin
        if (!bus.out_full) begin
          w_wr         = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobes are forced low while reset is held, since the idle state alone
  // would otherwise pop a non-empty FIFO during reset.
  assign bus.in_rd_en  = reset_n & w_rd;
  assign bus.out_wr_en = reset_n & w_wr;
  assign bus.out_din   = r_out_din;
  assign o_dbg_state   = r_state;

  // Shared multiplier operand select
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_MUL0: begin
        w_mul_a = B0;
        w_mul_b = r_x_cur;
      end
      S_MUL1: begin
        w_mul_a = B1;
        w_mul_b = r_x1;
      end
      S_MUL2: begin
        w_mul_a = A1;
        w_mul_b = r_y1;
      end
      default: begin
        w_mul_a = '0;
        w_mul_b = '0;
      end
    endcase
  end

  // Operands are sign-extended to the full product width so the low
  // 2*DATA_WIDTH bits of the product are the exact signed result.
  assign w_prod = {{DATA_WIDTH{w_mul_a[DATA_WIDTH-1]}}, w_mul_a} *
                  {{DATA_WIDTH{w_mul_b[DATA_WIDTH-1]}}, w_mul_b};
  assign w_dq   = dequantize(w_prod);

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x_cur   <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_acc     <= '0;
      r_out_din <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd) begin
            r_x_cur <= bus.in_dout;
            r_acc   <= '0;
          end
        end
        S_MUL0:  r_acc     <= r_acc + w_dq;
        S_MUL1:  r_acc     <= r_acc + w_dq;
        S_MUL2:  r_out_din <= r_acc + w_dq;
        S_WRITE: begin
          if (w_wr) begin
            r_x1 <= r_x_cur;
            r_y1 <= r_out_din;
          end
        end
        default: r_acc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Testbench: tb_iir_deemph
// Purpose: directed checks of the de-emphasis filter: reset values, positive
//   and negative impulse, output backpressure, empty input, reset during a
//   computation, and sustained throughput against a reference model.
module tb_iir_deemph;
  import fm_radio_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_n;
  iir_state_t dbg_state;

  always #5 clock = ~clock;

  iir_deemph_if bus ();

  iir_deemph dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DATA_WIDTH-1:0] in_q[$];
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] got_q[$];
  int                    got_cyc[$];
  int                    rd_cyc[$];
  logic                  stall        = 1'b0;
  logic                  overlap_seen = 1'b0;

  // ---------------- driver tasks ----------------
  // One clock cycle, entered and left at a falling edge. Drives the FIFO-side
  // inputs from in_q/stall, samples the strobes 1 time unit later, and models
  // the FIFOs: a pop removes the head of in_q, a push records out_din.
  task automatic step();
    bus.in_empty = (in_q.size() == 0);
    bus.in_dout  = (in_q.size() != 0) ? in_q[0] : '0;
    bus.out_full = stall;
    #1;
    if (bus.in_rd_en && bus.out_wr_en) overlap_seen = 1'b1;
    if (bus.in_rd_en) begin
      void'(in_q.pop_front());
      rd_cyc.push_back(cyc);
    end
    if (bus.out_wr_en) begin
      got_q.push_back(bus.out_din);
      got_cyc.push_back(cyc);
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic clear_queues();
    in_q.delete();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    rd_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    stall        = 1'b0;
    bus.in_empty = 1'b1;
    bus.in_dout  = '0;
    bus.out_full = 1'b0;
    clear_queues();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // Steps until n outputs have been pushed or the cycle budget runs out.
  task automatic run_writes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      step();
      k++;
    end
    n_vec++;
    if (got_q.size() < n) begin
      n_err++;
      $display("FAIL %s timeout: got %0d writes, required %0d", name, got_q.size(), n);
    end
  endtask

  // ---------------- reference model ----------------
  // Straight from the filter equation: SV signed division truncates toward
  // zero, each term is narrowed to 32 bits, sums wrap.
  function automatic logic [31:0] model_dq(input longint p);
    longint q;
    q = p / 1024;
    return 32'(q);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n      = 1'b0;
    bus.in_empty = 1'b0;
    bus.in_dout  = 32'd1024;
    bus.out_full = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_vec++;
    if (bus.in_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_rd_en: got %b, required 0", bus.in_rd_en);
    end
    n_vec++;
    if (bus.out_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_wr_en: got %b, required 0", bus.out_wr_en);
    end
    n_vec++;
    if (bus.out_din !== 32'd0) begin
      n_err++;
      $display("FAIL reset_out_din: got %0h, required 0", bus.out_din);
    end
    n_vec++;
    if (dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, S_IDLE);
    end
    do_reset();
  endtask

  task automatic test_impulse();
    do_reset();
    in_q  = '{32'd1024, 32'd0, 32'd0};
    exp_q = '{32'd178, 32'd293, 32'd190};
    run_writes(3, 40, "impulse");
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL impulse_y%0d: got %0d, required %0d", i,
                 $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
    if (got_cyc.size() > 0 && rd_cyc.size() > 0) begin
      n_vec++;
      if (got_cyc[0] - rd_cyc[0] !== 4) begin
        n_err++;
        $display("FAIL impulse_latency: got %0d clocks, required 4", got_cyc[0] - rd_cyc[0]);
      end
    end
  endtask

  task automatic test_negative_impulse();
    do_reset();
    in_q  = '{-32'sd1024, 32'd0};
    exp_q = '{-32'sd178, -32'sd293};
    run_writes(2, 30, "neg_impulse");
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL neg_impulse_y%0d: got %0d, required %0d", i,
                 $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    int bad_wr;
    int bad_din;
    do_reset();
    in_q  = '{32'd1024, 32'd0};
    stall = 1'b1;
    k = 0;
    while (dbg_state !== S_WRITE && k < 20) begin
      step();
      k++;
    end
    n_vec++;
    if (dbg_state !== S_WRITE) begin
      n_err++;
      $display("FAIL bp_reach_write: got state %0d, required %0d", dbg_state, S_WRITE);
    end
    bad_wr  = 0;
    bad_din = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_wr_en !== 1'b0) bad_wr++;
      if (bus.out_din !== 32'd178) bad_din++;
    end
    n_vec++;
    if (got_q.size() !== 0 || bad_wr !== 0) begin
      n_err++;
      $display("FAIL bp_no_write: got %0d writes (%0d strobes), required 0", got_q.size(), bad_wr);
    end
    n_vec++;
    if (rd_cyc.size() !== 1) begin
      n_err++;
      $display("FAIL bp_no_read: got %0d reads, required 1", rd_cyc.size());
    end
    n_vec++;
    if (bad_din !== 0) begin
      n_err++;
      $display("FAIL bp_din_stable: got %0d cycles off 178, required 0", bad_din);
    end
    stall = 1'b0;
    step();
    n_vec++;
    if (got_q.size() !== 1) begin
      n_err++;
      $display("FAIL bp_release_one_write: got %0d writes, required 1", got_q.size());
    end
    run_writes(2, 20, "bp_resume");
    if (got_q.size() >= 2) begin
      n_vec++;
      if (got_q[0] !== 32'd178 || got_q[1] !== 32'd293) begin
        n_err++;
        $display("FAIL bp_values: got %0d,%0d, required 178,293",
                 $signed(got_q[0]), $signed(got_q[1]));
      end
    end
  endtask

  task automatic test_empty();
    int not_idle;
    do_reset();
    not_idle = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dbg_state !== S_IDLE) not_idle++;
    end
    n_vec++;
    if (rd_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL empty_no_read: got %0d reads, required 0", rd_cyc.size());
    end
    n_vec++;
    if (got_q.size() !== 0) begin
      n_err++;
      $display("FAIL empty_no_write: got %0d writes, required 0", got_q.size());
    end
    n_vec++;
    if (not_idle !== 0) begin
      n_err++;
      $display("FAIL empty_state_idle: got %0d non-idle cycles, required 0", not_idle);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    in_q = '{32'd1024, 32'd1024};
    run_writes(1, 20, "rst_mid_first");
    k = 0;
    while (dbg_state !== S_MUL1 && k < 20) begin
      step();
      k++;
    end
    n_vec++;
    if (dbg_state !== S_MUL1 || bus.out_din !== 32'd178) begin
      n_err++;
      $display("FAIL rst_mid_setup: got state %0d din %0d, required state %0d din 178",
               dbg_state, $signed(bus.out_din), S_MUL1);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_din !== 32'd0 || bus.in_rd_en !== 1'b0 || bus.out_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got din %0d rd %b wr %b, required 0 0 0",
               $signed(bus.out_din), bus.in_rd_en, bus.out_wr_en);
    end
    n_vec++;
    if (dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL rst_mid_state: got %0d, required %0d", dbg_state, S_IDLE);
    end
    @(negedge clock);
    reset_n = 1'b1;
    clear_queues();
    in_q = '{32'd1024};
    run_writes(1, 20, "rst_mid_after");
    if (got_q.size() >= 1) begin
      n_vec++;
      if (got_q[0] !== 32'd178) begin
        n_err++;
        $display("FAIL rst_mid_history: got %0d, required 178", $signed(got_q[0]));
      end
    end
  endtask

  task automatic test_throughput();
    logic signed [31:0] xs[8];
    logic signed [31:0] x1;
    logic signed [31:0] y1;
    logic [31:0]        y;
    int                 bad_gap;
    do_reset();
    xs = '{32'sd1024, -32'sd2048, 32'sd5000, 32'sd123456,
           -32'sd7777777, 32'sd2147483647, -32'sd2147483648, 32'sd42};
    x1 = '0;
    y1 = '0;
    for (int i = 0; i < 8; i++) begin
      y = model_dq(longint'(xs[i]) * 178) + model_dq(longint'(x1) * 178) +
          model_dq(longint'(y1) * 666);
      exp_q.push_back(y);
      in_q.push_back(xs[i]);
      x1 = xs[i];
      y1 = y;
    end
    run_writes(8, 100, "throughput");
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL throughput_y%0d: got %0h, required %0h", i, got_q[i], exp_q[i]);
      end
    end
    bad_gap = 0;
    for (int i = 1; i < got_cyc.size(); i++) begin
      if (got_cyc[i] - got_cyc[i-1] !== 5) bad_gap++;
    end
    n_vec++;
    if (bad_gap !== 0) begin
      n_err++;
      $display("FAIL throughput_spacing: got %0d gaps not 5 clocks, required 0", bad_gap);
    end
    n_vec++;
    if (overlap_seen !== 1'b0) begin
      n_err++;
      $display("FAIL rd_wr_overlap: got %b, required 0", overlap_seen);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n      = 1'b0;
    bus.in_empty = 1'b1;
    bus.in_dout  = '0;
    bus.out_full = 1'b0;
    @(negedge clock);
    test_reset();
    test_impulse();
    test_negative_impulse();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
